// File: rtl/convert_from_10.sv
// Serial decimal-to-binary converter: accumulates acc = acc*10 + digit, MSD first.
// Optional macro CONV10_DIGIT_CHECK_EN rejects and flags digits above 9.
module convert_from_10 #(
  parameter int unsigned WIDTH      = 400,
  parameter int unsigned MAX_DIGITS = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       digit,
  input  logic             valid,
  input  logic             last,
  output logic [WIDTH-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [7:0]       count,
  output logic             bad_digit
);

  localparam int unsigned EXT_W = WIDTH + 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   binary_q, binary_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               bad_q, bad_d;
  logic               done_q, done_d;

  logic [EXT_W-1:0]   next_ext_c;
  logic [CNT_W-1:0]   count_inc_c;
  logic               digit_ok_c;
  logic               hit_max_c;

  // acc*10 as (acc<<3)+(acc<<1), kept 4 bits wider to expose carry-out
  assign next_ext_c  = (EXT_W'(binary_q) << 3) + (EXT_W'(binary_q) << 1) + EXT_W'(digit);
  assign count_inc_c = count_q + CNT_W'(1);

`ifdef CONV10_DIGIT_CHECK_EN
  assign digit_ok_c = (digit <= 4'd9);
`else
  assign digit_ok_c = 1'b1;
`endif

  // A rejected digit is not counted, so it can never reach the digit limit
  assign hit_max_c = digit_ok_c && (count_inc_c == CNT_W'(MAX_DIGITS));

  always_comb begin
    state_d    = state_q;
    binary_d   = binary_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    bad_d      = bad_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          binary_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          bad_d      = 1'b0;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (start) begin
          binary_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          bad_d      = 1'b0;
          state_d    = S_ACCUM;
        end else if (valid) begin
          if (digit_ok_c) begin
            binary_d   = next_ext_c[WIDTH-1:0];
            overflow_d = overflow_q | (next_ext_c[EXT_W-1:WIDTH] != 4'd0);
            count_d    = count_inc_c;
          end else begin
            bad_d = 1'b1;
          end
          if (last || hit_max_c) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      binary_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      binary_q   <= binary_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bad_q      <= bad_d;
      done_q     <= done_d;
    end
  end

  assign binary    = binary_q;
  assign busy      = (state_q == S_ACCUM);
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign count     = count_q;
  assign bad_digit = bad_q;

endmodule
